// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage: elastic DEPTH-entry in-order pipeline register with
// valid/ready on both sides plus stall, nullify and flush.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data/in_ctrl
// upstream beat; out_valid/out_ready/out_data/out_ctrl downstream head;
// stall, nullify, flush controls; count occupancy.
// Build option: PIPELINE_SKID_ZERO_INSTR_EN also zeroes data of nullified
// entries so the slot carries a nop instruction word.
module pipeline_skid_stage #(
   parameter int                DATA_W         = 32,
   parameter int                CTRL_W         = 16,
   parameter int                DEPTH          = 2,
   parameter logic [CTRL_W-1:0] CTRL_NULL_MASK = {CTRL_W{1'b1}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [CTRL_W-1:0]          in_ctrl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [CTRL_W-1:0]          out_ctrl,
   input  logic                       stall,
   input  logic                       nullify,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

`ifdef PIPELINE_SKID_ZERO_INSTR_EN
   localparam bit ZERO_DATA = 1'b1;
`else
   localparam bit ZERO_DATA = 1'b0;
`endif

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [CTRL_W-1:0] ctrl_q [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [DEPTH-1:0]  null_en;
   logic              full;
   logic              push;
   logic              pop;

   // Explicit wrap keeps non-power-of-2 depths in range.
   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + 1'b1;
   endfunction

   assign full      = (count == FULL_C);
   assign out_valid = (count != '0) & ~stall;
   assign pop       = out_valid & out_ready;
   assign in_ready  = ~stall & ~flush & (~full | pop);
   assign push      = in_valid & in_ready;
   assign out_data  = data_q[rd_ptr];
   assign out_ctrl  = ctrl_q[rd_ptr];

   // A slot is nullified only if it holds a live entry that is not
   // leaving this cycle; empty slots keep their contents so the idle
   // output value does not change.
   always_comb begin
      null_en = '0;
      for (int i = 0; i < DEPTH; i++) begin : g_res
         int off;
         off = i - int'(rd_ptr);
         if (off < 0) off = off + DEPTH;
         null_en[i] = nullify & (off < int'(count)) &
                      ~(pop & (rd_ptr == PW'(i)));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            ctrl_q[i] <= '0;
         end
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (!stall) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (null_en[i]) begin
               ctrl_q[i] <= ctrl_q[i] & ~CTRL_NULL_MASK;
               if (ZERO_DATA) data_q[i] <= '0;
            end
         end
         // Written after the nullify loop: when full with pop+push the
         // push lands in the slot just vacated by the head.
         if (push) begin
            data_q[wr_ptr] <= (nullify && ZERO_DATA) ? '0 : in_data;
            ctrl_q[wr_ptr] <= nullify ? (in_ctrl & ~CTRL_NULL_MASK)
                                      : in_ctrl;
            wr_ptr         <= ptr_nxt(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_nxt(rd_ptr);
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
